// File: rtl/mem_access.sv
// Data-memory access stage: runs a req/ack transaction to a variable-latency data memory,
// formats load data and stalls the upstream pipeline while an access is outstanding.
module mem_access #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Mem_size,
  input  logic        Mem_unsigned,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic        stall,
  output logic [31:0] Read_data,
  output logic        align_fault,
  output logic        timeout,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam bit               TO_EN     = (TIMEOUT != 32'd0);
  localparam int unsigned      TO_LAST_I = TO_EN ? (TIMEOUT - 32'd1) : 32'd0;
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_LAST_I);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             ld_r;
  logic [1:0]       ld_size_r;
  logic [1:0]       ld_lane_r;
  logic             ld_uns_r;
  logic             access_s;
  logic             misaligned_s;
  logic             issue_s;
  logic             timeout_hit_s;
  logic [3:0]       be_s;
  logic [31:0]      wdata_s;

  // Select the addressed byte/halfword lane and extend it to 32 bits.
  function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [1:0] size,
                                           input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // Request decode: alignment check, byte enables and lane-replicated store data.
  always_comb begin
    access_s      = MemRead | MemWrite;
    timeout_hit_s = TO_EN && (cnt_r == TO_LAST);
    case (Mem_size)
      2'b00: begin
        misaligned_s = 1'b0;
        be_s         = 4'b0001 << Address[1:0];
        wdata_s      = {4{Write_data[7:0]}};
      end
      2'b01: begin
        misaligned_s = Address[0];
        be_s         = Address[1] ? 4'b1100 : 4'b0011;
        wdata_s      = {2{Write_data[15:0]}};
      end
      2'b10: begin
        misaligned_s = |Address[1:0];
        be_s         = 4'b1111;
        wdata_s      = Write_data;
      end
      default: begin
        misaligned_s = 1'b1;
        be_s         = 4'b0000;
        wdata_s      = 32'h0000_0000;
      end
    endcase
    issue_s = access_s & ~misaligned_s;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; DONE never re-issues the instruction still sitting in EX/MEM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (issue_s) state_s = ST_WAIT;
        else         state_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (dmem_ack || timeout_hit_s) state_s = ST_DONE;
        else                           state_s = ST_WAIT;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Combinational outputs, forced low while reset is asserted.
  always_comb begin
    stall       = 1'b0;
    align_fault = 1'b0;
    if (!reset) begin
      stall       = 1'b0;
      align_fault = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          stall       = issue_s;
          align_fault = access_s & misaligned_s;
        end
        ST_WAIT: stall = 1'b1;
        default: begin
          stall       = 1'b0;
          align_fault = 1'b0;
        end
      endcase
    end
  end

  // Memory interface, wait counter and load-result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0000_0000;
      dmem_wdata <= 32'h0000_0000;
      dmem_be    <= 4'b0000;
      Read_data  <= 32'h0000_0000;
      timeout    <= 1'b0;
      cnt_r      <= '0;
      ld_r       <= 1'b0;
      ld_size_r  <= 2'b00;
      ld_lane_r  <= 2'b00;
      ld_uns_r   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (issue_s) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite;
            dmem_addr  <= {Address[31:2], 2'b00};
            dmem_wdata <= wdata_s;
            dmem_be    <= be_s;
            cnt_r      <= '0;
            ld_r       <= ~MemWrite;
            ld_size_r  <= Mem_size;
            ld_lane_r  <= Address[1:0];
            ld_uns_r   <= Mem_unsigned;
          end
        end
        ST_WAIT: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (ld_r) Read_data <= fmt_load(dmem_rdata, ld_size_r, ld_lane_r, ld_uns_r);
          end else if (timeout_hit_s) begin
            dmem_req <= 1'b0;
            timeout  <= 1'b1;
            if (ld_r) Read_data <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed and randomized bench for mem_access against an arithmetic reference model;
// a second instance with TIMEOUT=4 exercises the abort path.
module tb_mem_access;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, Mem_unsigned = 1'b0;
  logic [1:0]  Mem_size = 2'b00;
  logic [31:0] Address = 32'h0, Write_data = 32'h0, dmem_rdata = 32'h0;
  logic        dmem_ack = 1'b0;
  logic        block_b = 1'b0;
  logic        ack_b;

  logic        stall, align_fault, timeout, dmem_req, dmem_we;
  logic [31:0] Read_data, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        b_stall, b_align_fault, b_timeout, b_req, b_we;
  logic [31:0] b_read_data, b_addr, b_wdata;
  logic [3:0]  b_be;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd_model = 32'h0;

  assign ack_b = dmem_ack & ~block_b;

  always #5 clock = ~clock;

  mem_access dut (
    .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Mem_size(Mem_size), .Mem_unsigned(Mem_unsigned), .Address(Address),
    .Write_data(Write_data), .stall(stall), .Read_data(Read_data),
    .align_fault(align_fault), .timeout(timeout), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  mem_access #(.TIMEOUT(4), .CNT_W(8)) dut_b (
    .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Mem_size(Mem_size), .Mem_unsigned(Mem_unsigned), .Address(Address),
    .Write_data(Write_data), .stall(b_stall), .Read_data(b_read_data),
    .align_fault(b_align_fault), .timeout(b_timeout), .dmem_req(b_req),
    .dmem_we(b_we), .dmem_addr(b_addr), .dmem_wdata(b_wdata),
    .dmem_be(b_be), .dmem_rdata(dmem_rdata), .dmem_ack(ack_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic exp_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    return (a % (32'd1 << sz)) != 32'd0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> ((a % 32'd4) * 32'd8)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = (rd >> ((a & 32'd2) * 32'd8)) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 32'd1 << (a % 32'd4);
    if (sz == 2'd1) return ((a & 32'd2) != 32'd0) ? 32'd12 : 32'd3;
    return 32'd15;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  task automatic do_access(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int delay);
    MemWrite = wr;
    MemRead = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    Mem_size = sz; Mem_unsigned = uns; Address = a; Write_data = wd;
    #1;
    if (exp_mis(sz, a)) begin
      chk("align_fault", {31'd0, align_fault}, 32'd1);
      chk("fault_stall", {31'd0, stall}, 32'd0);
      tick;
      chk("fault_no_req", {31'd0, dmem_req}, 32'd0);
      MemRead = 1'b0; MemWrite = 1'b0;
      #1;
      chk("fault_cleared", {31'd0, align_fault}, 32'd0);
      chk("fault_read_data", Read_data, rd_model);
    end else begin
      chk("issue_stall", {31'd0, stall}, 32'd1);
      chk("issue_no_req_yet", {31'd0, dmem_req}, 32'd0);
      for (int i = 1; i <= delay; i++) begin
        tick;
        dmem_ack = (i == delay);
        dmem_rdata = rd;
        #1;
        chk("wait_stall", {31'd0, stall}, 32'd1);
        chk("wait_req", {31'd0, dmem_req}, 32'd1);
        chk("wait_we", {31'd0, dmem_we}, {31'd0, wr});
        chk("wait_addr", dmem_addr, a & 32'hFFFF_FFFC);
        chk("wait_be", {28'd0, dmem_be}, exp_be(sz, a));
        chk("wait_wdata", dmem_wdata, exp_wdata(sz, wd));
      end
      if (!wr) rd_model = exp_load(sz, uns, a, rd);
      tick;
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      #1;
      chk("done_stall", {31'd0, stall}, 32'd0);
      chk("done_req", {31'd0, dmem_req}, 32'd0);
      chk("read_data", Read_data, rd_model);
      chk("done_timeout", {31'd0, timeout}, 32'd0);
      tick;
      chk("no_reissue", {31'd0, dmem_req}, 32'd0);
      MemRead = 1'b0; MemWrite = 1'b0;
      #1;
      chk("idle_stall", {31'd0, stall}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        wr, uns;
    logic [1:0]  sz;
    logic [31:0] a, wd, rd;

    // Reset state on both instances.
    #3;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_read_data", Read_data, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_b_req", {31'd0, b_req}, 32'd0);
    #4 reset = 1'b1;
    tick;

    // Stray ack while idle does nothing.
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick;
    dmem_ack = 1'b0;
    #1;
    chk("stray_ack_req", {31'd0, dmem_req}, 32'd0);
    chk("stray_ack_rdata", Read_data, 32'd0);

    do_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hCAFE_BABE, 1);
    chk("word_load_value", Read_data, 32'hCAFE_BABE);
    do_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_0012, 2);
    chk("byte_signed", Read_data, 32'hFFFF_FF80);
    do_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF_0012, 3);
    chk("byte_unsigned", Read_data, 32'h0000_0080);
    chk("b_tracks_load", b_read_data, 32'h0000_0080);

    // Abort after 4 WAIT cycles on the TIMEOUT=4 instance.
    block_b = 1'b1;
    MemRead = 1'b1; MemWrite = 1'b0; Mem_size = 2'd2; Mem_unsigned = 1'b0; Address = 32'h300;
    #1;
    chk("to_issue_stall", {31'd0, b_stall}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick;
      chk("to_wait_stall", {31'd0, b_stall}, 32'd1);
      chk("to_wait_req", {31'd0, b_req}, 32'd1);
      chk("to_wait_pulse", {31'd0, b_timeout}, 32'd0);
    end
    tick;
    chk("to_done_req", {31'd0, b_req}, 32'd0);
    chk("to_done_pulse", {31'd0, b_timeout}, 32'd1);
    chk("to_done_stall", {31'd0, b_stall}, 32'd0);
    chk("to_read_data_zero", b_read_data, 32'd0);
    tick;
    chk("to_pulse_end", {31'd0, b_timeout}, 32'd0);
    chk("to_idle_req", {31'd0, b_req}, 32'd0);
    MemRead = 1'b0;
    #1;
    chk("to_idle_stall", {31'd0, b_stall}, 32'd0);
    chk("main_still_wait", {31'd0, stall}, 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'h5A5A_A5A5;
    tick;
    dmem_ack = 1'b0;
    rd_model = 32'h5A5A_A5A5;
    #1;
    chk("main_late_ack", Read_data, rd_model);
    chk("main_late_stall", {31'd0, stall}, 32'd0);
    tick;
    block_b = 1'b0;

    do_access(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234_ABCD, 32'h1111_2222, 5);
    chk("store_keeps_rdata", Read_data, 32'h5A5A_A5A5);
    do_access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 1);
    do_access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1);

    // Reset in the second WAIT cycle, access left present.
    MemRead = 1'b1; MemWrite = 1'b0; Mem_size = 2'd2; Address = 32'h400;
    tick;
    tick;
    reset = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_rdata", Read_data, 32'd0);
    rd_model = 32'h0;
    #1 reset = 1'b1;
    #1;
    chk("rst_rel_stall", {31'd0, stall}, 32'd1);
    chk("rst_rel_no_req", {31'd0, dmem_req}, 32'd0);
    do_access(1'b0, 2'd1, 1'b0, 32'h402, 32'h0, 32'h8001_7FFF, 2);
    chk("half_signed", Read_data, 32'hFFFF_8001);

    for (int n = 0; n < 60; n++) begin
      wr  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      a   = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      wd  = $urandom;
      rd  = $urandom;
      do_access(wr, sz, uns, a, wd, rd, $urandom_range(1, 6));
      if ($urandom_range(0, 3) == 0) tick;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Data-memory access stage between the EX/MEM pipeline register and the MEM/WB register.
- Takes load/store control plus address and store data from EX/MEM, and runs a req/ack transaction to an external data memory of variable latency.
- Formats load data as byte, half or word, with sign or zero extension, and drives it to MEM/WB Read_data_in.
- Asserts stall to freeze the upstream pipeline while an access is outstanding.

Parameters:
- TIMEOUT, 255: maximum cycles to wait for dmem_ack before aborting; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must hold TIMEOUT.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- MemRead  in  1  load request from EX/MEM.
- MemWrite  in  1  store request from EX/MEM; takes priority if both are high.
- Mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- Mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
- Address  in  32  byte address (ALU result).
- Write_data  in  32  store data, right-aligned.
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- Read_data  out  32  formatted load data to MEM/WB Read_data_in.
- align_fault  out  1  one-cycle pulse on misaligned or illegal-size access.
- timeout  out  1  one-cycle pulse on an aborted access.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address, {Address[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables, little-endian.
- dmem_rdata  in  32  memory read data, valid with ack.
- dmem_ack  in  1  transaction complete.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - All outputs 0: stall, Read_data, align_fault, timeout, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be.
  - Wait counter = 0.
  - Reset mid-transaction drops dmem_req immediately. No completion is reported and Read_data is not updated.
- access = MemRead | MemWrite.
- misaligned = (size==01 & A[0]) | (size==10 & A[1:0]!=0) | size==11.
- States:
  - IDLE:
    - access & !misaligned: stall=1 combinationally. Register dmem_req=1, dmem_we=MemWrite, addr, wdata and be. Counter=0. Next state WAIT.
    - access & misaligned: align_fault=1 for this cycle only, stall=0, no memory request, Read_data unchanged. Stay in IDLE.
    - No access: stall=0, stay in IDLE.
  - WAIT:
    - stall=1. dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be are held stable.
    - dmem_ack=1: drop dmem_req next cycle. If the access is a load, register the formatted dmem_rdata into Read_data. Next state DONE.
    - No ack: counter increments.
    - TIMEOUT!=0 and counter reaches TIMEOUT-1 with no ack: drop dmem_req, timeout=1 for one cycle, Read_data=0. Next state DONE.
  - DONE:
    - stall=0 for exactly one cycle so the pipeline advances.
    - EX/MEM inputs are ignored, because they still hold the completed instruction; this prevents re-issue.
    - Next state IDLE.
- Latency: minimum 2 stall cycles when ack arrives in the first WAIT cycle. Stall cycles = 1 + WAIT cycles. Read_data is valid from the DONE cycle and is held until the next completed load.
- Byte enables and store data:
  - Byte: be = 1<<A[1:0]; wdata = {4{Write_data[7:0]}}.
  - Half: be = A[1] ? 1100 : 0011; wdata = {2{Write_data[15:0]}}.
  - Word: be = 1111; wdata = Write_data.
- Load formatting:
  - Byte: lane A[1:0] of dmem_rdata, extended to 32 bits.
  - Half: halfword A[1] of dmem_rdata, extended to 32 bits.
  - Word: dmem_rdata unchanged.
  - Extension is zero when Mem_unsigned=1, sign otherwise.
- A store never modifies Read_data.
- dmem_ack outside WAIT is ignored.

Test Plan:
- Word load, Address=0x100, memory returns 0xCAFEBABE with ack in the first WAIT cycle:
  - stall high for 2 cycles; dmem_addr=0x100, be=1111, we=0.
  - Read_data=0xCAFEBABE in DONE, then stall=0.
- Byte loads, Address=0x103, rdata=0x80FF0012:
  - Mem_unsigned=0 -> Read_data=0xFFFFFF80.
  - Repeat with Mem_unsigned=1 -> Read_data=0x00000080.
- Half store, Address=0x202, Write_data=0x1234ABCD:
  - dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200.
  - Ack after 5 cycles -> stall for 6 cycles; Read_data unchanged.
- Word load at 0x101:
  - align_fault pulses for 1 cycle; no dmem_req; stall=0.
  - Mem_size=11 at an aligned address also faults.
- TIMEOUT=4, load with ack never asserted:
  - dmem_req drops after 4 WAIT cycles; timeout pulses for 1 cycle; Read_data=0; one DONE cycle, then IDLE.
- reset driven low in the 2nd WAIT cycle:
  - dmem_req and stall drop asynchronously before the next edge.
  - After release: IDLE, with a fresh request issued only if access is still present.
